// File: rtl/memarb_nport.sv
// rtl/memarb_nport.sv - N-port round-robin arbiter onto one Wishbone B4 classic master
// Optional shared read line buffer enabled by defining MEMARB_LINEBUF_EN.
module memarb_nport #(
  parameter int N_PORTS    = 2,
  parameter int LINE_WIDTH = 128,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PORTS-1:0]      valid,
  input  logic [32*N_PORTS-1:0]   addr,
  input  logic [32*N_PORTS-1:0]   datain,
  input  logic [N_PORTS-1:0]      wr,
  output logic [32*N_PORTS-1:0]   dataout,
  output logic [N_PORTS-1:0]      ready,
  output logic [N_PORTS-1:0]      err,
  output logic [31:0]             wb_adr_o,
  output logic [LINE_WIDTH-1:0]   wb_dat_o,
  input  logic [LINE_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_we_o,
  output logic [LINE_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic                    wb_cyc_o
);

  localparam int SEL_WIDTH = LINE_WIDTH / 8;
  localparam int WORDS     = LINE_WIDTH / 32;
  localparam int OFFW      = $clog2(SEL_WIDTH);
  localparam int WI        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int RW        = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, DONE} state_t;

  state_t                 state_q;
  logic [PW-1:0]          rr_q, port_q, gnt_idx, rr_next;
  logic [RW-1:0]          retry_q;
  logic                   wr_q;
  logic [WI-1:0]          widx_q, widx_sel;
  logic                   gnt_found, wr_sel, lb_hit;
  logic [31:0]            addr_sel, din_sel, rd_word, lb_word;
  logic [N_PORTS-1:0]     ready_q, err_q;
  logic [31:0]            dout_q [N_PORTS];
  logic                   cyc_q, we_q;
  logic [31:0]            adr_q;
  logic [LINE_WIDTH-1:0]  dat_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   unused_addr_lsb;

  // Fallback pass picks the lowest valid port; second pass overrides with the lowest valid port >= rr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (valid[p]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(p);
      end
    end
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (valid[p] && PW'(p) >= rr_q) gnt_idx = PW'(p);
    end
  end

  always_comb begin
    addr_sel = '0;
    din_sel  = '0;
    wr_sel   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt_idx == PW'(p)) begin
        addr_sel = addr[32*p +: 32];
        din_sel  = datain[32*p +: 32];
        wr_sel   = wr[p];
      end
    end
  end

  generate
    if (WORDS > 1) begin : g_widx
      assign widx_sel = addr_sel[OFFW-1:2];
    end else begin : g_widx1
      assign widx_sel = 1'b0;
    end
  endgenerate

  assign unused_addr_lsb = ^addr_sel[1:0];
  assign rr_next = (int'(port_q) == N_PORTS - 1) ? '0 : port_q + 1'b1;

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (widx_q == WI'(w)) rd_word = wb_dat_i[32*w +: 32];
    end
  end

`ifdef MEMARB_LINEBUF_EN
  logic                  lb_valid_q;
  logic [LINE_WIDTH-1:0] lb_line_q;
  logic [31-OFFW:0]      lb_tag_q, tag_q;

  assign lb_hit = lb_valid_q && !wr_sel && (addr_sel[31:OFFW] == lb_tag_q);
  always_comb begin
    lb_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (widx_sel == WI'(w)) lb_word = lb_line_q[32*w +: 32];
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      port_q  <= '0;
      retry_q <= '0;
      wr_q    <= 1'b0;
      widx_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      ready_q <= '0;
      err_q   <= '0;
      for (int p = 0; p < N_PORTS; p++) dout_q[p] <= '0;
`ifdef MEMARB_LINEBUF_EN
      lb_valid_q <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            port_q  <= gnt_idx;
            wr_q    <= wr_sel;
            widx_q  <= widx_sel;
            retry_q <= '0;
`ifdef MEMARB_LINEBUF_EN
            tag_q   <= addr_sel[31:OFFW];
`endif
            if (lb_hit) begin
              ready_q[gnt_idx] <= 1'b1;
              dout_q[gnt_idx]  <= lb_word;
              state_q          <= DONE;
            end else begin
              adr_q   <= {addr_sel[31:OFFW], {OFFW{1'b0}}};
              dat_q   <= {WORDS{din_sel}};
              we_q    <= wr_sel;
              sel_q   <= wr_sel ? (SEL_WIDTH'(4'hF) << (4 * widx_sel)) : '1;
              cyc_q   <= 1'b1;
              state_q <= BUS;
            end
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            cyc_q           <= 1'b0;
            ready_q[port_q] <= 1'b1;
            if (!wr_q) dout_q[port_q] <= rd_word;
`ifdef MEMARB_LINEBUF_EN
            if (!wr_q) begin
              lb_line_q  <= wb_dat_i;
              lb_tag_q   <= tag_q;
              lb_valid_q <= 1'b1;
            end else if (tag_q == lb_tag_q) begin
              lb_valid_q <= 1'b0;
            end
`endif
            state_q <= DONE;
          end else if (wb_err_i) begin
            cyc_q           <= 1'b0;
            ready_q[port_q] <= 1'b1;
            err_q[port_q]   <= 1'b1;
            state_q         <= DONE;
          end else if (wb_rty_i) begin
            cyc_q <= 1'b0;
            if (retry_q == RW'(MAX_RETRY - 1)) begin
              ready_q[port_q] <= 1'b1;
              err_q[port_q]   <= 1'b1;
              state_q         <= DONE;
            end else begin
              retry_q <= retry_q + 1'b1;
              state_q <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          cyc_q   <= 1'b1;
          state_q <= BUS;
        end
        DONE: begin
          rr_q    <= rr_next;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (genvar p = 0; p < N_PORTS; p++) begin : g_dout
      assign dataout[32*p +: 32] = dout_q[p];
    end
  endgenerate

  assign ready    = ready_q;
  assign err      = err_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_memarb_nport.sv
// tb/tb_memarb_nport.sv - scoreboard bench for memarb_nport (default and MEMARB_LINEBUF_EN builds)
module tb_memarb_nport;
  localparam int NP = 2;
  localparam int LW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   valid, wr, ready, err;
  logic [32*NP-1:0] addr, datain, dataout;
  logic [31:0]     wb_adr_o;
  logic [LW-1:0]   wb_dat_o, wb_dat_i;
  logic            wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [LW/8-1:0] wb_sel_o;

  memarb_nport #(.N_PORTS(NP), .LINE_WIDTH(LW), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .datain(datain), .wr(wr),
    .dataout(dataout), .ready(ready), .err(err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        e;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          resp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic        hold_bus = 1'b0;
  logic [LW-1:0] bus_line = {32'h4444_4444, 32'h3333_3333, 32'hDEADBEEF, 32'h1111_1111};
  logic [31:0] model_dout [NP];
  exp_t        mon_e;
  logic [NP-1:0] mon_rdy;
  int          resp_r;

  task automatic push_exp(input int port, input logic e, input logic chk, input logic [31:0] data);
    exp_t x;
    x.port = port; x.e = e; x.chk = chk; x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl: cyc/stb/we=%b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if (wb_sel_o !== '0) begin errors++; $display("FAIL reset_sel: got %h expected 0", wb_sel_o); end
    checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", wb_adr_o); end
    checks++; if (wb_dat_o !== '0) begin errors++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
    checks++; if (ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (err !== '0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (dataout !== '0) begin errors++; $display("FAIL reset_dataout: got %h expected 0", dataout); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    int tgt = done_cnt + 1;
    model_dout[0] = 32'hDEADBEEF;
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    resp_q.push_back(0);
    @(negedge clk);
    valid = 2'b01; wr = 2'b00; addr[31:0] = 32'h104;
    @(negedge clk);
    checks++; if (wb_adr_o !== 32'h100) begin errors++; $display("FAIL read_adr: got %h expected 00000100", wb_adr_o); end
    checks++; if (wb_sel_o !== 16'hFFFF) begin errors++; $display("FAIL read_sel: got %h expected ffff", wb_sel_o); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) begin errors++; $display("FAIL read_ctl: cyc/stb/we=%b expected 110", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    @(negedge clk);
    checks++; if (ready !== 2'b01) begin errors++; $display("FAIL read_latency: ready=%b expected 01", ready); end
    valid = 2'b00;
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL read_timeout: done=%0d expected %0d", done_cnt, tgt); end
  endtask

  task automatic test_write();
    int tgt = done_cnt + 1;
    push_exp(1, 1'b0, 1'b1, model_dout[1]);
    resp_q.push_back(0);
    @(negedge clk);
    valid = 2'b10; wr = 2'b10; addr[63:32] = 32'h20C; datain[63:32] = 32'h1234_5678;
    @(negedge clk);
    checks++; if (wb_we_o !== 1'b1) begin errors++; $display("FAIL write_we: got %b expected 1", wb_we_o); end
    checks++; if (wb_sel_o !== 16'hF000) begin errors++; $display("FAIL write_sel: got %h expected f000", wb_sel_o); end
    checks++; if (wb_adr_o !== 32'h200) begin errors++; $display("FAIL write_adr: got %h expected 00000200", wb_adr_o); end
    checks++; if (wb_dat_o !== {4{32'h1234_5678}}) begin errors++; $display("FAIL write_dat: got %h expected 4x12345678", wb_dat_o); end
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL write_timeout: done=%0d expected %0d", done_cnt, tgt); end
    valid = 2'b00; wr = 2'b00;
  endtask

  task automatic test_round_robin();
    int tgt = done_cnt + 4;
    model_dout[0] = 32'h1111_1111;
    model_dout[1] = 32'h3333_3333;
    for (int i = 0; i < 2; i++) begin
      push_exp(0, 1'b0, 1'b1, model_dout[0]);
      push_exp(1, 1'b0, 1'b1, model_dout[1]);
    end
    @(negedge clk);
    valid = 2'b11; wr = 2'b00; addr = {32'h008, 32'h000};
    for (int t = 0; t < 100 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL rr_timeout: done=%0d expected %0d", done_cnt, tgt); end
    valid = 2'b00;
  endtask

  task automatic test_retry_ok();
    int tgt = done_cnt + 1;
    logic [5:0] stb_hist = '0;
    model_dout[0] = 32'hDEADBEEF;
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    resp_q.push_back(2); resp_q.push_back(2); resp_q.push_back(0);
    @(negedge clk);
    valid = 2'b01; wr = 2'b00; addr[31:0] = 32'h114;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stb_hist = {stb_hist[4:0], wb_stb_o};
    end
    checks++; if (stb_hist !== 6'b101010) begin errors++; $display("FAIL retry_backoff: stb pattern %b expected 101010", stb_hist); end
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL retry_timeout: done=%0d expected %0d", done_cnt, tgt); end
    valid = 2'b00;
  endtask

  task automatic test_retry_exhaust();
    int tgt = done_cnt + 1;
    push_exp(1, 1'b1, 1'b1, model_dout[1]);
    repeat (3) resp_q.push_back(2);
    @(negedge clk);
    valid = 2'b10; wr = 2'b00; addr[63:32] = 32'h104;
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL exhaust_timeout: done=%0d expected %0d", done_cnt, tgt); end
    valid = 2'b00;
  endtask

  task automatic test_bus_err();
    int tgt = done_cnt + 1;
    push_exp(0, 1'b1, 1'b1, model_dout[0]);
    resp_q.push_back(1);
    @(negedge clk);
    valid = 2'b01; wr = 2'b01; addr[31:0] = 32'h100; datain[31:0] = 32'hCAFE_F00D;
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL buserr_timeout: done=%0d expected %0d", done_cnt, tgt); end
    valid = 2'b00; wr = 2'b00;
  endtask

  task automatic test_reset_mid();
    hold_bus = 1'b1;
    @(negedge clk);
    valid = 2'b10; wr = 2'b00; addr[63:32] = 32'h200;
    repeat (3) @(negedge clk);
    checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin errors++; $display("FAIL stall_bus: cyc/stb=%b expected 11", {wb_cyc_o, wb_stb_o}); end
    rst = 1'b1; valid = 2'b00;
    @(negedge clk);
    checks++; if ({wb_cyc_o, wb_stb_o, ready} !== 4'b0000) begin errors++; $display("FAIL midreset_abort: cyc/stb/ready=%b expected 0000", {wb_cyc_o, wb_stb_o, ready}); end
    rst = 1'b0; hold_bus = 1'b0;
    model_dout[0] = '0; model_dout[1] = '0;
    repeat (3) @(negedge clk);
    checks++; if (dataout !== '0) begin errors++; $display("FAIL midreset_dataout: got %h expected 0", dataout); end
  endtask

  task automatic test_rr_after_reset();
    int tgt = done_cnt + 1;
    model_dout[0] = 32'h3333_3333;
    model_dout[1] = 32'h4444_4444;
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    push_exp(1, 1'b0, 1'b1, model_dout[1]);
    @(negedge clk);
    valid = 2'b11; wr = 2'b00; addr = {32'h10C, 32'h108};
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    valid[0] = 1'b0;
    for (int t = 0; t < 50 && done_cnt < tgt + 1; t++) @(negedge clk);
    checks++; if (done_cnt < tgt + 1) begin errors++; $display("FAIL rr_reset_timeout: done=%0d expected %0d", done_cnt, tgt + 1); end
    valid = 2'b00;
  endtask

`ifdef MEMARB_LINEBUF_EN
  task automatic test_linebuf();
    int tgt = done_cnt + 1;
    logic cyc_seen;
    model_dout[0] = 32'h1111_1111;
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    @(negedge clk);
    valid = 2'b01; wr = 2'b00; addr[31:0] = 32'h100;
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    valid = 2'b00;
    repeat (2) @(negedge clk);
    model_dout[0] = 32'h3333_3333;
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    valid = 2'b01; addr[31:0] = 32'h108;
    @(negedge clk);
    checks++; if ({ready, wb_cyc_o} !== 3'b010) begin errors++; $display("FAIL lb_hit: ready/cyc=%b expected 010", {ready, wb_cyc_o}); end
    valid = 2'b00;
    tgt = done_cnt + 2;
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    repeat (2) @(negedge clk);
    valid = 2'b01; wr = 2'b01; addr[31:0] = 32'h100;
    for (int t = 0; t < 50 && done_cnt < tgt - 1; t++) @(negedge clk);
    valid = 2'b00; wr = 2'b00;
    repeat (2) @(negedge clk);
    push_exp(0, 1'b0, 1'b1, model_dout[0]);
    valid = 2'b01; addr[31:0] = 32'h108;
    @(negedge clk);
    cyc_seen = wb_cyc_o;
    checks++; if (cyc_seen !== 1'b1) begin errors++; $display("FAIL lb_invalidate: cyc=%b expected 1", cyc_seen); end
    for (int t = 0; t < 50 && done_cnt < tgt; t++) @(negedge clk);
    checks++; if (done_cnt < tgt) begin errors++; $display("FAIL lb_timeout: done=%0d expected %0d", done_cnt, tgt); end
    valid = 2'b00;
  endtask
`endif

  initial begin
    rst = 1'b1; valid = '0; wr = '0; addr = '0; datain = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    model_dout[0] = '0; model_dout[1] = '0;
    fork
      forever begin
        @(posedge clk); #2;
        if (ready !== '0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: ready=%b expected none", ready);
          end else begin
            mon_e = exp_q.pop_front();
            mon_rdy = '0;
            mon_rdy[mon_e.port] = 1'b1;
            checks++; if (ready !== mon_rdy) begin errors++; $display("FAIL grant_port: ready=%b expected %b", ready, mon_rdy); end
            checks++; if (err !== (mon_e.e ? mon_rdy : '0)) begin errors++; $display("FAIL err_flag: err=%b expected %b", err, mon_e.e ? mon_rdy : '0); end
            if (mon_e.chk) begin
              checks++;
              if (dataout[32*mon_e.port +: 32] !== mon_e.data) begin errors++; $display("FAIL dataout%0d: got %h expected %h", mon_e.port, dataout[32*mon_e.port +: 32], mon_e.data); end
            end
          end
          done_cnt++;
        end
      end
      forever begin
        @(negedge clk);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = bus_line;
        if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && !hold_bus) begin
          resp_r = 0;
          if (resp_q.size() > 0) resp_r = resp_q.pop_front();
          case (resp_r)
            1:       wb_err_i = 1'b1;
            2:       wb_rty_i = 1'b1;
            default: wb_ack_i = 1'b1;
          endcase
        end
      end
    join_none
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_retry_ok();
    test_retry_exhaust();
    test_bus_err();
    test_reset_mid();
    test_rr_after_reset();
`ifdef MEMARB_LINEBUF_EN
    test_linebuf();
`endif
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
